// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: assembles big-endian words and writes them into instruction memory.
// Checksum logic is built only when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
    parameter int          DEPTH      = 512,
    parameter logic [31:0] END_MARKER = 32'hFFFFFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   wr_en,
    output logic [31:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic                   stall,
    output logic                   done,
    output logic                   full,
    output logic [$clog2(DEPTH):0] word_count,
    output logic [31:0]            checksum
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_byte_idx;
    logic [23:0]    r_shift;
    logic           r_wr_en;
    logic [31:0]    r_wr_addr;
    logic [31:0]    r_wr_data;
    logic [CW-1:0]  r_count;
    logic           r_full;

    logic           w_accept;
    logic           w_last;
    logic [31:0]    w_word;
    logic           w_marker;
    logic [CW-1:0]  w_count_inc;
    logic           w_fill;
    logic           w_session_start;

    assign w_accept        = rx_valid && rx_ready;
    assign w_last          = w_accept && (r_byte_idx == 2'd3);
    assign w_word          = {r_shift, rx_data};
    assign w_marker        = w_last && (w_word == END_MARKER);
    assign w_count_inc     = r_count + 1'b1;
    assign w_fill          = r_wr_en && (w_count_inc == DEPTH_C);
    assign w_session_start = (r_state == IDLE) && start;

    // rx_ready drops during the write cycle so a word never overlaps its own write-back.
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                stall    = 1'b1;
                rx_ready = !r_wr_en;
                if (w_fill || w_marker) w_next = DONE;
            end
            DONE: begin
                stall  = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_count    <= '0;
            r_full     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_last && !w_marker;
            if (w_last && !w_marker) begin
                r_wr_data <= w_word;
                r_wr_addr <= 32'(r_count) << 2;
            end
            if (w_session_start) begin
                r_byte_idx <= 2'd0;
                r_shift    <= 24'd0;
                r_count    <= '0;
                r_full     <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_shift    <= {r_shift[15:0], rx_data};
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
                if (r_wr_en) begin
                    r_count <= w_count_inc;
                    if (w_fill) r_full <= 1'b1;
                end
            end
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 32'd0;
        end else if (w_session_start) begin
            r_checksum <= 32'd0;
        end else if (r_wr_en) begin
            r_checksum <= r_checksum ^ r_wr_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign full       = r_full;
    assign word_count = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a DEPTH=512 instance and a DEPTH=4 instance share stimulus via sel4.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       reset, start, rx_valid, sel4;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam logic [31:0] EXP_CKS_A = 32'h01F5A808;
    localparam logic [31:0] EXP_CKS_B = 32'h0000000F;
`else
    localparam logic [31:0] EXP_CKS_A = 32'h0;
    localparam logic [31:0] EXP_CKS_B = 32'h0;
`endif

    logic        a_ready, a_wr_en, a_stall, a_done, a_full;
    logic [31:0] a_addr, a_data, a_cks;
    logic [9:0]  a_count;
    logic        b_ready, b_wr_en, b_stall, b_done, b_full;
    logic [31:0] b_addr, b_data, b_cks;
    logic [2:0]  b_count;

    instruction_loader u_a (
        .clk(clk), .reset(reset), .start(start & ~sel4), .rx_data(rx_data),
        .rx_valid(rx_valid & ~sel4), .rx_ready(a_ready), .wr_en(a_wr_en),
        .wr_addr(a_addr), .wr_data(a_data), .stall(a_stall), .done(a_done),
        .full(a_full), .word_count(a_count), .checksum(a_cks)
    );

    instruction_loader #(.DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .start(start & sel4), .rx_data(rx_data),
        .rx_valid(rx_valid & sel4), .rx_ready(b_ready), .wr_en(b_wr_en),
        .wr_addr(b_addr), .wr_data(b_data), .stall(b_stall), .done(b_done),
        .full(b_full), .word_count(b_count), .checksum(b_cks)
    );

    wire        m_ready = sel4 ? b_ready : a_ready;
    wire        m_wr_en = sel4 ? b_wr_en : a_wr_en;
    wire [31:0] m_addr  = sel4 ? b_addr  : a_addr;
    wire [31:0] m_data  = sel4 ? b_data  : a_data;
    wire        m_stall = sel4 ? b_stall : a_stall;
    wire        m_done  = sel4 ? b_done  : a_done;
    wire        m_full  = sel4 ? b_full  : a_full;
    wire [31:0] m_count = sel4 ? 32'(b_count) : 32'(a_count);
    wire [31:0] m_cks   = sel4 ? b_cks   : a_cks;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds the byte until the loader takes it; a missing rx_ready is a failed comparison.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!m_ready && k < 50) begin
            step();
            k++;
        end
        if (!m_ready) chk("rx_ready_timeout", 32'(m_ready), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_wr_en"}, 32'(m_wr_en), 32'd1);
        chk({tag, "_addr"}, m_addr, addr);
        chk({tag, "_data"}, m_data, data);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sel4 = 1'b0;
        step(); step();

        // reset state, both instances
        for (int s = 0; s < 2; s++) begin
            sel4 = s[0];
            #1;
            chk("rst_stall", 32'(m_stall), 32'd0);
            chk("rst_ready", 32'(m_ready), 32'd0);
            chk("rst_wr_en", 32'(m_wr_en), 32'd0);
            chk("rst_done", 32'(m_done), 32'd0);
            chk("rst_full", 32'(m_full), 32'd0);
            chk("rst_count", m_count, 32'd0);
            chk("rst_cks", m_cks, 32'd0);
            chk("rst_addr", m_addr, 32'd0);
            chk("rst_data", m_data, 32'd0);
        end
        sel4 = 1'b0;
        reset = 1'b0;
        step();

        // basic load
        rx_valid = 1'b1; rx_data = 8'h55;
        step();
        rx_valid = 1'b0;
        chk("idle_ignores_rx", 32'(m_stall), 32'd0);
        pulse_start();
        chk("load_stall", 32'(m_stall), 32'd1);
        chk("load_ready", 32'(m_ready), 32'd1);
        send_word(32'h02538820);
        chk_write("basic_w0", 32'h0, 32'h02538820);
        send_word(32'h00A62020);
        chk_write("basic_w1", 32'h4, 32'h00A62020);
        send_word(32'h03000008);
        chk_write("basic_w2", 32'h8, 32'h03000008);
        send_word(32'hFFFFFFFF);
        chk("basic_done", 32'(m_done), 32'd1);
        chk("basic_marker_nowr", 32'(m_wr_en), 32'd0);
        chk("basic_count_done", m_count, 32'd3);
        step();
        chk("basic_done_pulse", 32'(m_done), 32'd0);
        chk("basic_stall_low", 32'(m_stall), 32'd0);
        chk("basic_ready_low", 32'(m_ready), 32'd0);
        chk("basic_count", m_count, 32'd3);
        chk("basic_cks", m_cks, EXP_CKS_A);
        step();
        chk("basic_hold_count", m_count, 32'd3);

        // byte gaps
        pulse_start();
        chk("gap_count_clr", m_count, 32'd0);
        repeat (5) step(); send_byte(8'h01);
        repeat (5) step(); send_byte(8'h2A);
        repeat (5) step(); send_byte(8'h40);
        repeat (5) step();
        chk("gap_no_early_wr", 32'(m_wr_en), 32'd0);
        send_byte(8'h20);
        chk_write("gap_w0", 32'h0, 32'h012A4020);
        step();
        chk("gap_wr_one_cycle", 32'(m_wr_en), 32'd0);
        chk("gap_count", m_count, 32'd1);
        send_word(32'hFFFFFFFF);
        step();

        // reset mid-word
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_stall", 32'(m_stall), 32'd0);
        chk("midrst_ready", 32'(m_ready), 32'd0);
        pulse_start();
        send_word(32'h014B4820);
        chk_write("midrst_w0", 32'h0, 32'h014B4820);
        step();
        send_word(32'hFFFFFFFF);
        step();

        // start during LOAD
        pulse_start();
        send_word(32'h11223344);
        chk_write("restart_w0", 32'h0, 32'h11223344);
        pulse_start();
        chk("restart_ignored", m_count, 32'd1);
        send_word(32'h55667788);
        chk_write("restart_w1", 32'h4, 32'h55667788);
        step();
        chk("restart_count", m_count, 32'd2);
        send_word(32'hFFFFFFFF);
        step();

        // full case on the DEPTH=4 instance
        sel4 = 1'b1;
        #1;
        pulse_start();
        send_word(32'h00000001);
        chk_write("full_w0", 32'h0, 32'h00000001);
        send_word(32'h00000002);
        chk_write("full_w1", 32'h4, 32'h00000002);
        send_word(32'h00000004);
        chk_write("full_w2", 32'h8, 32'h00000004);
        send_word(32'h00000008);
        chk_write("full_w3", 32'hC, 32'h00000008);
        chk("full_not_yet", 32'(m_full), 32'd0);
        step();
        chk("full_done", 32'(m_done), 32'd1);
        chk("full_flag", 32'(m_full), 32'd1);
        chk("full_count", m_count, 32'd4);
        rx_data = 8'h77; rx_valid = 1'b1;
        chk("full_ready_low", 32'(m_ready), 32'd0);
        step();
        chk("full_done_pulse", 32'(m_done), 32'd0);
        chk("full_ready_idle", 32'(m_ready), 32'd0);
        chk("full_stall_low", 32'(m_stall), 32'd0);
        step();
        rx_valid = 1'b0;
        chk("full_sticky", 32'(m_full), 32'd1);
        chk("full_count_hold", m_count, 32'd4);
        chk("full_no_wr", 32'(m_wr_en), 32'd0);
        chk("full_cks", m_cks, EXP_CKS_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
